// File: rtl/multiplexed_display.sv
// multiplexed_display: time-multiplexed hex display scanner with PWM dimming,
// per-digit blink, leading-zero suppression and frame-synchronous double-buffered loads.
module multiplexed_display #(
   parameter int NUM_DIGITS = 8,
   parameter int PRESCALE_W = 11,
   parameter int BLINK_W    = 6
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   point_in,
   input  logic [NUM_DIGITS-1:0]   enable_in,
   input  logic [NUM_DIGITS-1:0]   blink_in,
   input  logic                    load,
   input  logic [2:0]              brightness,
   input  logic                    lz_blank,
   output logic [7:0]              segment,
   output logic [NUM_DIGITS-1:0]   digit,
   output logic                    load_ack,
   output logic                    frame_start
);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   logic [PRESCALE_W-1:0]   r_pre;
   logic [IW-1:0]           r_idx;
   logic [BLINK_W-1:0]      r_frame;
   logic [4*NUM_DIGITS-1:0] r_val, r_pval;
   logic [NUM_DIGITS-1:0]   r_pt, r_en, r_bl, r_ppt, r_pen, r_pbl;
   logic                    r_pend, r_ack, r_fs;
   logic [7:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_dig;
   logic                    w_tick, w_last, w_bnd, w_pwm, w_blank, w_drive;
   logic [3:0]              w_nib;
   logic [6:0]              w_glyph;
   logic [NUM_DIGITS-1:0]   w_hi_zero;
   assign w_tick = &r_pre;
   assign w_last = r_idx == IW'(NUM_DIGITS - 1);
   assign w_bnd  = w_tick & w_last;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pre   <= '0;
         r_idx   <= '0;
         r_frame <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
         if (w_tick) r_idx <= w_last ? '0 : r_idx + 1'b1;
         if (w_bnd) r_frame <= r_frame + 1'b1;
      end
   end
   // A load landing on the boundary bypasses the pending buffer so it is never lost.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_val  <= '0;
         r_pt   <= '0;
         r_en   <= '0;
         r_bl   <= '0;
         r_pval <= '0;
         r_ppt  <= '0;
         r_pen  <= '0;
         r_pbl  <= '0;
         r_pend <= 1'b0;
         r_ack  <= 1'b0;
         r_fs   <= 1'b0;
      end else begin
         r_ack <= w_bnd & (load | r_pend);
         r_fs  <= w_bnd;
         if (w_bnd & load) begin
            r_val  <= value_in;
            r_pt   <= point_in;
            r_en   <= enable_in;
            r_bl   <= blink_in;
            r_pend <= 1'b0;
         end else if (w_bnd & r_pend) begin
            r_val  <= r_pval;
            r_pt   <= r_ppt;
            r_en   <= r_pen;
            r_bl   <= r_pbl;
            r_pend <= 1'b0;
         end else if (load) begin
            r_pval <= value_in;
            r_ppt  <= point_in;
            r_pen  <= enable_in;
            r_pbl  <= blink_in;
            r_pend <= 1'b1;
         end
      end
   end
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_hz
      assign w_hi_zero[i] = (r_val >> (4 * i)) == '0;
   end
   assign w_nib   = r_val[{r_idx, 2'b00} +: 4];
   assign w_blank = ~r_en[r_idx] | (r_bl[r_idx] & r_frame[BLINK_W-1]) |
                    (lz_blank & (r_idx != '0) & w_hi_zero[r_idx]);
   assign w_pwm   = r_pre[PRESCALE_W-1 -: 3] <= brightness;
   assign w_drive = ~w_blank & w_pwm;
   // Active-low {a,b,c,d,e,f,g}.
   always_comb begin
      w_glyph = 7'h7F;
      case (w_nib)
         4'h0: w_glyph = 7'b0000001;
         4'h1: w_glyph = 7'b1001111;
         4'h2: w_glyph = 7'b0010010;
         4'h3: w_glyph = 7'b0000110;
         4'h4: w_glyph = 7'b1001100;
         4'h5: w_glyph = 7'b0100100;
         4'h6: w_glyph = 7'b0100000;
         4'h7: w_glyph = 7'b0001111;
         4'h8: w_glyph = 7'b0000000;
         4'h9: w_glyph = 7'b0000100;
         4'hA: w_glyph = 7'b0001000;
         4'hB: w_glyph = 7'b1100000;
         4'hC: w_glyph = 7'b0110001;
         4'hD: w_glyph = 7'b1000010;
         4'hE: w_glyph = 7'b0110000;
         4'hF: w_glyph = 7'b0111000;
         default: w_glyph = 7'h7F;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_seg <= 8'hFF;
         r_dig <= '1;
      end else begin
         r_seg <= w_drive ? {w_glyph, ~r_pt[r_idx]} : 8'hFF;
         r_dig <= w_drive ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      end
   end
   assign segment     = r_seg;
   assign digit       = r_dig;
   assign load_ack    = r_ack;
   assign frame_start = r_fs;
endmodule

// File: tb/tb_multiplexed_display.sv
// tb_multiplexed_display: scoreboard bench; stimulus queues every expected lit cycle and
// load_ack per frame, a negedge monitor pops and compares whatever the display presents.
module tb_multiplexed_display;
   typedef struct packed {logic ack; logic [5:0] dig; logic [7:0] seg;} exp_t;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [23:0] value_in = '0;
   logic [5:0]  point_in = '0, enable_in = '0, blink_in = '0;
   logic        load = 1'b0;
   logic [2:0]  brightness = '0;
   logic        lz_blank = 1'b0;
   logic [7:0]  segment;
   logic [5:0]  digit;
   logic        load_ack, frame_start;
   exp_t        q[$];
   int          passed = 0, total = 0, t = 0;
   always #5 clock = ~clock;
   multiplexed_display #(.NUM_DIGITS(6), .PRESCALE_W(3), .BLINK_W(2)) dut (
      .clock(clock), .reset_n(reset_n), .value_in(value_in), .point_in(point_in),
      .enable_in(enable_in), .blink_in(blink_in), .load(load), .brightness(brightness),
      .lz_blank(lz_blank), .segment(segment), .digit(digit), .load_ack(load_ack),
      .frame_start(frame_start));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask
   // Lit cycles are handled before acks so same-cycle events pop in queue order.
   always @(negedge clock) begin
      if (reset_n) begin
         if (digit !== 6'h3F) begin
            if (q.size() == 0 || q[0].ack) begin
               total++;
               $display("FAIL lit: got digit %h seg %h, want dark", digit, segment);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("digit", 32'(digit), 32'(e.dig));
               chk("segment", 32'(segment), 32'(e.seg));
            end
         end else chk("dark_seg", 32'(segment), 32'hFF);
         if (load_ack) begin
            total++;
            if (q.size() > 0 && q[0].ack) begin
               void'(q.pop_front());
               passed++;
            end else $display("FAIL load_ack: got 1, want 0");
         end
      end
   end
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clock);
         t++;
      end
   endtask
   task automatic wait_fs();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!frame_start && n < 100);
      chk("frame_sync", 32'(frame_start), 32'd1);
      t = 0;
   endtask
   task automatic end_frame();
      cyc(48 - t);
      chk("frame_start", 32'(frame_start), 32'd1);
      t = 0;
   endtask
   task automatic frame(input logic [47:0] segs, input logic [5:0] mask,
                        input logic [2:0] br, input logic lz);
      brightness = br;
      lz_blank = lz;
      for (int i = 0; i < 6; i++)
         for (int p = 0; p < 8; p++)
            if (mask[i] && p <= int'(br)) q.push_back({1'b0, ~(6'b1 << i), segs[8*i +: 8]});
   endtask
   task automatic ld(input logic [23:0] v, input logic [5:0] p, input logic [5:0] e,
                     input logic [5:0] b, input logic ack);
      value_in = v;
      point_in = p;
      enable_in = e;
      blink_in = b;
      load = 1'b1;
      if (ack) q.push_back({1'b1, 6'h00, 8'h00});
      cyc(1);
      load = 1'b0;
   endtask
   task automatic reset_chk();
      chk("rst_digit", 32'(digit), 32'h3F);
      chk("rst_segment", 32'(segment), 32'hFF);
      chk("rst_load_ack", 32'(load_ack), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
   endtask
   initial begin
      repeat (3) @(negedge clock);
      reset_chk();
      reset_n = 1'b1;
      wait_fs();
      repeat (3) begin
         frame(48'h0, 6'h00, 3'd7, 1'b0);
         end_frame();
      end
      frame(48'h0, 6'h00, 3'd7, 1'b0);
      cyc(10); ld(24'h012345, 6'h01, 6'h3F, 6'h00, 1'b1);
      end_frame();
      frame(48'h039F250D9948, 6'h3F, 3'd7, 1'b0);
      cyc(10); ld(24'h000045, 6'h00, 6'h3F, 6'h00, 1'b1);
      end_frame();
      frame(48'hFFFFFFFF9949, 6'h03, 3'd7, 1'b1);
      cyc(10); ld(24'h000000, 6'h00, 6'h3F, 6'h00, 1'b1);
      end_frame();
      frame(48'hFFFFFFFFFF03, 6'h01, 3'd7, 1'b1);
      cyc(10); ld(24'h012345, 6'h00, 6'h3F, 6'h00, 1'b1);
      end_frame();
      frame(48'h039F250D9949, 6'h3F, 3'd0, 1'b0);
      end_frame();
      frame(48'h039F250D9949, 6'h3F, 3'd3, 1'b0);
      cyc(5); ld(24'h111111, 6'h3F, 6'h3F, 6'h00, 1'b0);
      cyc(10); ld(24'hFEDCBA, 6'h3F, 6'h3F, 6'h00, 1'b1);
      end_frame();
      frame(48'h70608462C010, 6'h3F, 3'd7, 1'b0);
      cyc(47); ld(24'h987654, 6'h00, 6'h3F, 6'h01, 1'b1);
      end_frame();
      frame(48'h09011F414999, 6'h3E, 3'd7, 1'b0); end_frame();
      frame(48'h09011F414999, 6'h3F, 3'd7, 1'b0); end_frame();
      frame(48'h09011F414999, 6'h3F, 3'd7, 1'b0); end_frame();
      frame(48'h09011F414999, 6'h3E, 3'd7, 1'b0); end_frame();
      frame(48'h09011F414999, 6'h3E, 3'd7, 1'b0);
      cyc(10); ld(24'h000000, 6'h00, 6'h00, 6'h00, 1'b1);
      end_frame();
      frame(48'h0, 6'h00, 3'd7, 1'b0);
      cyc(10); ld(24'h012345, 6'h00, 6'h3F, 6'h00, 1'b0);
      cyc(5);
      reset_n = 1'b0;
      #1;
      reset_chk();
      cyc(2);
      reset_n = 1'b1;
      wait_fs();
      frame(48'h0, 6'h00, 3'd7, 1'b0);
      end_frame();
      cyc(5);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/multiplexed_display.md
MULTIPLEXED_DISPLAY -- requirements
Module: multiplexed_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of scanned digits (legal range 2..16, power of two not required).
REQ-002 SHALL have parameter PRESCALE_W, default 11, prescaler width; digit dwell is 2^PRESCALE_W cycles (minimum 3).
REQ-003 SHALL have parameter BLINK_W, default 6, frame-counter width; blink half-period is 2^(BLINK_W-1) frames.
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port value_in  in  4*NUM_DIGITS  hex nibbles; nibble i is digit i.
REQ-007 SHALL have port point_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-008 SHALL have port enable_in  in  NUM_DIGITS  digit enable, 0 = blank.
REQ-009 SHALL have port blink_in  in  NUM_DIGITS  per-digit blink enable.
REQ-010 SHALL have port load  in  1  request to capture value_in, point_in, enable_in and blink_in.
REQ-011 SHALL have port brightness  in  3  on-time of (brightness+1)/8 of each dwell; sampled live.
REQ-012 SHALL have port lz_blank  in  1  leading-zero suppression; sampled live.
REQ-013 SHALL have port segment  out  8  {a,b,c,d,e,f,g,dp} in bits [7:0], active-low, registered.
REQ-014 SHALL have port digit  out  NUM_DIGITS  one-cold digit select, active-low, registered.
REQ-015 SHALL have port load_ack  out  1  one-cycle pulse when captured data becomes active.
REQ-016 SHALL have port frame_start  out  1  one-cycle pulse when the scan index wraps to 0.

Function
REQ-017 The prescaler SHALL count up freely; tick = prescaler all-ones.
REQ-018 The scan index SHALL advance on tick and wrap from NUM_DIGITS-1 to 0; boundary = tick while index = NUM_DIGITS-1.
REQ-019 The frame counter (BLINK_W bits) SHALL increment at each boundary and wrap; blink phase = its MSB.
REQ-020 A load sampled high SHALL copy the four inputs into pending registers and set pending; a further load before the boundary SHALL overwrite pending (last wins).
REQ-021 At a boundary with pending set, the active registers SHALL take pending contents and pending SHALL clear; a boundary without pending SHALL leave active registers unchanged.
REQ-022 Load coincident with a boundary SHALL write the inputs directly into the active registers and clear pending.
REQ-023 load_ack SHALL pulse for exactly one cycle, the cycle after any active-register update; frame_start SHALL pulse the cycle after each boundary.
REQ-024 Digit i is blanked when: enable inactive; OR blink active and phase = 1; OR lz_blank = 1, i > 0, and nibbles i..NUM_DIGITS-1 are all zero.
REQ-025 PWM on SHALL be true when prescaler[PRESCALE_W-1 -: 3] <= brightness.
REQ-026 digit SHALL drive only bit [index] low, and only when that digit is not blanked and PWM is on; otherwise all ones.
REQ-027 segment SHALL be the active-low standard hex glyph (0-F; b and d lowercase) with dp = ~point when the digit drives; otherwise 8'hFF.
REQ-028 segment and digit SHALL reflect prescaler and index state with one cycle of register latency and SHALL change together.

Reset
REQ-029 reset_n low SHALL immediately clear the prescaler, index, frame counter, active and pending registers and the pending flag.
REQ-030 During reset: digit all ones, segment 8'hFF, load_ack 0, frame_start 0. After release the display SHALL stay dark until the first load is applied.
REQ-031 Reset mid-frame SHALL discard any pending load without a load_ack.

Verification (NUM_DIGITS=6, PRESCALE_W=3, BLINK_W=2)
REQ-032 Reset: reset_n low -> digit 6'h3F, segment 8'hFF; release with no load for 200 cycles -> remains dark, no load_ack.
REQ-033 load value_in 24'h012345, enable 6'h3F, point 6'h01, brightness 7 -> load_ack at first boundary; digit0 then shows segment 8'h48 with digit 6'h3E for 8 cycles; digit1 shows 8'h99.
REQ-034 lz_blank=1, value 24'h000045 -> digits 2..5 dark; value 24'h000000 -> only digit0 lit, segment 8'h03.
REQ-035 brightness 0 -> digit low 1 cycle of every 8-cycle dwell; brightness 3 -> 4 cycles.
REQ-036 Two loads before one boundary -> only the second data shown, exactly one load_ack; load on the boundary cycle -> applied at that edge, load_ack on the next cycle.
REQ-037 blink_in 6'h01 -> digit0 dark for 2 frames and lit for 2 frames, alternating; reset_n pulsed while load pending -> dark, no load_ack.
